// File: rtl/inv_sub_shift_pkg.sv
// Shared AES helpers for the inverse round datapath: inverse S-box table,
// state byte indexing and the InvSubBytes/InvShiftRows FSM encoding.
package inv_sub_shift_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Index 0 is the leftmost byte, so INV_SBOX[x] is the inverse of x
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic int byte_row(input int k);
      return k % 4;
   endfunction

   function automatic int byte_col(input int k);
      return k / 4;
   endfunction

   function automatic int byte_ofs(input int r, input int c);
      return r + 4 * c;
   endfunction

endpackage

// File: rtl/inv_sub_shift_if.sv
// Ready/valid handshake carrying one 128-bit AES state in and one out.
interface inv_sub_shift_if;
   logic         in_valid;
   logic         in_ready;
   logic [0:127] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [0:127] out_state;

   modport slave (
      input  in_valid, in_state, out_ready,
      output in_ready, out_valid, out_state
   );

   modport master (
      output in_valid, in_state, out_ready,
      input  in_ready, out_valid, out_state
   );
endinterface

// File: rtl/inv_sub_shift_sbox.sv
// Combinational FIPS-197 inverse S-box, one byte wide.
module inv_sbox
   import inv_sub_shift_pkg::*;
(
   input  logic [7:0] x,
   output logic [7:0] y
);

   assign y = INV_SBOX[x];

endmodule

// File: rtl/inv_sub_shift.sv
// InvShiftRows on capture, then InvSubBytes one column per cycle through
// four shared S-boxes; the result is held in the working register.
module inv_sub_shift
   import inv_sub_shift_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   inv_sub_shift_if.slave  bus
);

   state_t             state;
   logic [1:0]         col_cnt;
   logic [0:127]       wreg;
   logic [0:127]       perm;
   logic [3:0][7:0]    sb_in;
   logic [3:0][7:0]    sb_out;
   logic [6:0]         col_base;
   logic               out_valid_q;
   logic               xfer_in;

   // Output byte (r,c) takes input byte (r,(c-r) mod 4)
   for (genvar k = 0; k < 16; k++) begin : g_perm
      localparam int SRC = byte_ofs(byte_row(k), (byte_col(k) + 4 - byte_row(k)) % 4);
      assign perm[8*k +: 8] = bus.in_state[8*SRC +: 8];
   end

   assign col_base = {col_cnt, 5'd0};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      assign sb_in[i] = wreg[col_base + 7'(8*i) +: 8];
      inv_sbox u_sbox (.x(sb_in[i]), .y(sb_out[i]));
   end

   // In DONE a new block may enter on the same edge the result leaves
   assign bus.in_ready  = !rst && (state == IDLE || (state == DONE && bus.out_ready));
   assign xfer_in       = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_state = wreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         col_cnt     <= 2'd0;
         wreg        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer_in) begin
                  wreg    <= perm;
                  col_cnt <= 2'd0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               for (int i = 0; i < 4; i++)
                  wreg[col_base + 7'(8*i) +: 8] <= sb_out[i];
               col_cnt <= col_cnt + 2'd1;
               if (col_cnt == 2'd3) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (xfer_in) begin
                     wreg    <= perm;
                     col_cnt <= 2'd0;
                     state   <= BUSY;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_sub_shift.sv
// Directed bench for inv_sub_shift: FIPS-197 vectors, backpressure, streaming,
// reset mid-block, with an independent GF(2^8) software model.
module tb_inv_sub_shift;

   logic clk;
   logic rst;
   int   nvec = 0;
   int   nerr = 0;
   logic [7:0] inv_tbl [256];

   inv_sub_shift_if bus ();

   inv_sub_shift dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int j = 0; j < 8; j++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Forward S-box from first principles: GF inverse then affine map
   function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
      logic [7:0] v = 8'h00;
      if (x != 8'h00)
         for (int j = 1; j < 256; j++)
            if (gmul(x, 8'(j)) == 8'h01) v = 8'(j);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [0:127] model(input logic [0:127] s);
      logic [0:127] o;
      for (int k = 0; k < 16; k++) begin
         int r = k % 4;
         int c = k / 4;
         int src = r + 4 * ((c + 4 - r) % 4);
         o[8*k +: 8] = inv_tbl[s[8*src +: 8]];
      end
      return o;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [0:127] blk);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_state = blk;
      #1;
      while (!bus.in_ready && n < 20) begin
         step();
         n++;
      end
      if (!bus.in_ready) chk("push_timeout", 0, 1);
      step();
      bus.in_valid = 1'b0;
   endtask

   // Scrambles in_state every cycle so the in-flight block must be isolated
   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         bus.in_state = {$urandom, $urandom, $urandom, $urandom};
         step();
         lat++;
      end
      if (!bus.out_valid) chk("done_timeout", 0, 1);
   endtask

   task automatic pop();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      #1;
   endtask

   task automatic run_block(input string tag, input logic [0:127] blk, input logic [0:127] exp);
      int lat;
      push(blk);
      wait_done(lat);
      chk({tag, "_lat"}, 128'(lat), 128'd4);
      chk({tag, "_data"}, bus.out_state, exp);
      pop();
      chk({tag, "_idle"}, 128'(bus.out_valid), 128'd0);
   endtask

   initial begin
      logic [0:127] blk [3];
      logic [0:127] exp_v;
      logic [0:127] held;
      int           lat;
      int           cyc;
      int           nin;
      int           nout;
      int           last;
      int           bad;
      logic         tin;
      logic         tout;

      for (int x = 0; x < 256; x++) inv_tbl[fwd_sbox(8'(x))] = 8'(x);

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_state  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_out_state", bus.out_state, 128'd0);
      chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 128'(bus.in_ready), 128'd1);

      // Known-answer vectors
      run_block("fips", 128'h7ad5fda789ef4e272bca100b3d9ff59f,
                128'hbd6e7c3df2b5779e0b61216e8b10b689);
      run_block("zero", 128'h0, {16{8'h52}});
      run_block("all63", {16{8'h63}}, 128'h0);

      // Backpressure in DONE
      exp_v = model(128'h000102030405060708090a0b0c0d0e0f);
      push(128'h000102030405060708090a0b0c0d0e0f);
      wait_done(lat);
      chk("bp_data", bus.out_state, exp_v);
      held = bus.out_state;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         bus.in_state = {$urandom, $urandom, $urandom, $urandom};
         bus.in_valid = i[0];
         step();
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_state !== held) bad++;
      end
      bus.in_valid = 1'b0;
      chk("bp_hold", 128'(bad), 128'd0);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_ready_comb", 128'(bus.in_ready), 128'd1);
      step();
      bus.out_ready = 1'b0;
      #1;
      chk("bp_pop_valid", 128'(bus.out_valid), 128'd0);
      chk("bp_pop_idle", 128'(bus.in_ready), 128'd1);
      step();
      chk("bp_single", 128'(bus.out_valid), 128'd0);

      // Back-to-back stream of three blocks
      blk[0] = 128'h3243f6a8885a308d313198a2e0370734;
      blk[1] = 128'hffeeddccbbaa99887766554433221100;
      blk[2] = 128'h0123456789abcdeffedcba9876543210;
      bus.in_valid  = 1'b1;
      bus.in_state  = blk[0];
      bus.out_ready = 1'b1;
      cyc = 0; nin = 0; nout = 0; last = 0;
      while (nout < 3 && cyc < 60) begin
         #1;
         tin  = bus.in_valid && bus.in_ready;
         tout = bus.out_valid && bus.out_ready;
         held = bus.out_state;
         step();
         cyc++;
         if (tin) begin
            nin++;
            if (nin < 3) bus.in_state = blk[nin];
            else begin
               bus.in_valid = 1'b0;
               bus.in_state = {$urandom, $urandom, $urandom, $urandom};
            end
         end
         if (tout) begin
            chk($sformatf("stream_data%0d", nout), held, model(blk[nout]));
            if (nout > 0) chk($sformatf("stream_gap%0d", nout), 128'(cyc - last), 128'd5);
            last = cyc;
            nout++;
         end
      end
      if (nout < 3) chk("stream_timeout", 128'(nout), 128'd3);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      step();

      // Reset on the second BUSY cycle
      push(128'hdeadbeef0badf00dcafebabe12345678);
      step();
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 128'(bus.out_valid), 128'd0);
      chk("mid_rst_state", bus.out_state, 128'd0);
      chk("mid_rst_ready", 128'(bus.in_ready), 128'd0);
      bus.out_ready = 1'b1;
      step();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.out_valid !== 1'b0) bad++;
      end
      chk("mid_rst_no_out", 128'(bad), 128'd0);
      bus.out_ready = 1'b0;
      run_block("after_rst", 128'h7ad5fda789ef4e272bca100b3d9ff59f,
                128'hbd6e7c3df2b5779e0b61216e8b10b689);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/inv_sub_shift.md
INV_SUB_SHIFT -- requirements
Module: inv_sub_shift

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 128 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  in_state holds a block to process.
REQ-005 in_ready  output  1  block can accept in_state this cycle.
REQ-006 in_state  input  [0:127]  cipher state; byte k = in_state[8k:8k+7], row r = k mod 4, column c = k div 4.
REQ-007 out_valid  output  1  out_state holds a finished block.
REQ-008 out_ready  input  1  downstream (AddRoundKey/InvMixColumns path) accepts out_state.
REQ-009 out_state  output  [0:127]  InvSubBytes(InvShiftRows(in_state)), same byte ordering as in_state.

Function
REQ-010 Transfer in SHALL occur on a rising edge with in_valid=1 and in_ready=1; transfer out SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-011 InvShiftRows SHALL map output byte (r,c) to input byte (r,(c-r) mod 4), so row r rotates right by r.
REQ-012 InvSubBytes SHALL replace each byte with the FIPS-197 inverse S-box value.
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 IDLE: in_ready=1 and out_valid=0; an in-transfer SHALL capture in_state already InvShiftRows-permuted into the working register, clear col_cnt to 0 and enter BUSY.
REQ-015 BUSY: in_ready=0 and out_valid=0; each cycle SHALL substitute the 4 bytes of column col_cnt through 4 S-box instances, write them back, and increment col_cnt.
REQ-016 col_cnt is 2 bits; when col_cnt=3 is processed, the FSM SHALL enter DONE and col_cnt SHALL wrap to 0.
REQ-017 DONE: out_valid=1; out_state SHALL equal the working register and stay stable until an out-transfer.
REQ-018 DONE without out_ready: the FSM SHALL hold DONE and in_ready SHALL be 0.
REQ-019 DONE with out_ready=1: in_ready SHALL be 1, as a combinational function of out_ready and state.
REQ-020 DONE with out_ready=1 and in_valid=1: the FSM SHALL complete the out-transfer and capture the new block on the same edge, then enter BUSY.
REQ-021 DONE with out_ready=1 and in_valid=0: the FSM SHALL return to IDLE.
REQ-022 Latency: out_valid SHALL rise exactly 4 clock cycles after the in-transfer edge; sustained throughput SHALL be one block per 5 cycles.
REQ-023 in_state changes while BUSY or DONE SHALL NOT affect the block in flight.
REQ-024 out_state SHALL be driven directly from a register, with no combinational path from in_state.

Reset
REQ-025 rst=1 SHALL immediately force: state=IDLE, col_cnt=0, working register=0, out_valid=0, out_state=0.
REQ-026 in_ready SHALL be 0 while rst=1 and SHALL be 1 on the first cycle after rst is released.
REQ-027 Reset during BUSY or DONE SHALL discard the in-flight block, and no out-transfer of it SHALL occur.

Structure
REQ-028 The shared AES package SHALL hold the 256-entry inverse S-box constant table and the byte/column index helpers (row, column, byte offset).
REQ-029 The combinational inverse S-box SHALL be a sub-module inv_sbox (8-bit in, 8-bit out), instantiated 4 times.
REQ-030 The FSM state encoding SHALL be a typedef in the package.
REQ-031 The top SHALL contain only the FSM, col_cnt, the working register and the permutation wiring.

Verification
REQ-032 Send in_state=7ad5fda789ef4e272bca100b3d9ff59f with out_ready=1 -> out_state=bd6e7c3df2b5779e0b61216e8b10b689, and out_valid rises 4 cycles after the transfer.
REQ-033 Send all-zero in_state -> out_state = 0x52 repeated 16 times; send all-0x63 in_state -> out_state=0.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, in_ready stays 0, out_state is stable; then pulse out_ready -> one transfer, return to IDLE.
REQ-035 Stream 3 blocks with in_valid and out_ready held at 1 -> out-transfers every 5 cycles, in order, each matching a software model.
REQ-036 Assert rst on the 2nd BUSY cycle -> all outputs go to 0 at once, no out-transfer follows, and the next block processes correctly.
REQ-037 Randomize in_state between transfers while BUSY -> the result depends only on the captured block.
